reg_memory: RTL and testbench
=============================

Name: reg_memory

Overview:
- General-purpose register file for the processor datapath: 16 registers of 32 bits each.
- Provides two independent combinational read ports (Ra→Data1, Rb→Data2) and one synchronous write port (Rd, DataInput, DataInputON).
- Sits between the decode stage (register indices) and the execute and writeback stages (operands, result).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, register index width.
- DEPTH, 16 (2**ADDR_W), number of registers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- Ra  input  ADDR_W  read index, port 1.
- Rb  input  ADDR_W  read index, port 2.
- Rd  input  ADDR_W  write index.
- DataInput  input  DATA_W  write data.
- DataInputON  input  1  write enable, active-high.
- Data1  output  DATA_W  contents of register Ra.
- Data2  output  DATA_W  contents of register Rb.

Interface (already decided): one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Storage: DEPTH x DATA_W flip-flops. No register is hardwired; R0 is writable.
- Reset: on a rising clk edge with rst_n=0, all registers clear to 0.
  - Reset has priority over a write in the same cycle.
  - Data1 and Data2 therefore read 0 after reset.
- Write: on a rising clk edge with rst_n=1 and DataInputON=1, reg[Rd] <= DataInput.
  - With DataInputON=0, no register changes, regardless of Rd or DataInput (including X/undriven DataInput).
- Read: Data1 = reg[Ra] and Data2 = reg[Rb], purely combinational. They change within the same cycle as Ra/Rb change, with zero-cycle latency.
  - Ra and Rb may be equal; both outputs then show the same value.
- Write latency: a written value becomes visible on a read port only after the rising edge that performs the write (absent the optional feature).
- Read-during-write, same index, no bypass: the output shows the old value until the edge, then the new value.
- Every index is valid; no out-of-range case exists.
- Reset mid-operation: a pending write in the reset cycle is dropped; all registers read 0 from the next edge on.
- No handshake and no stall: a write completes in exactly one clk edge.

Optional Feature:
- Macro: REGMEMORY_BYPASS_EN.
- Defined: write-first forwarding. When DataInputON=1, rst_n=1 and Ra==Rd, Data1 = DataInput combinationally in the same cycle; likewise Data2 when Rb==Rd. Register state updates at the edge as normal.
- Not defined: no forwarding. Reads always return the stored register contents (pure read-old-value behaviour).

Test Plan:
1. Reset: rst_n=0 for one edge, then Ra=0, Rb=15 -> Data1=0, Data2=0; all 16 registers read 0.
2. Write R0: Rd=0, DataInput=100, DataInputON=1 for one edge, Ra=0 -> Data1=100 after the edge (before the edge: 0 without bypass, 100 with REGMEMORY_BYPASS_EN).
3. Write R2: Rd=2, DataInput=100, DataInputON pulsed one edge; Ra=2, Rb=0 -> Data1=100, Data2=100; other registers remain 0.
4. Write disable: DataInputON=0, Rd=5, DataInput=0xDEADBEEF over several edges -> Ra=5 reads 0.
5. Dual read and overwrite: write R7=0x12345678, then R7=0xCAFEF00D; Ra=Rb=7 -> both outputs 0xCAFEF00D.
6. Reset priority: rst_n=0 and DataInputON=1, Rd=3, DataInput=55 on the same edge -> R3 reads 0; previously written R0 and R2 also read 0.

Source files
------------

// File: rtl/reg_memory.sv
// 16x32 general-purpose register file: two combinational read ports, one synchronous write port.
// Define REGMEMORY_BYPASS_EN to forward in-flight write data to a matching read port in the same cycle.
module reg_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] DataInput,
    input  logic              DataInputON,
    output logic [DATA_W-1:0] Data1,
    output logic [DATA_W-1:0] Data2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (DataInputON)
            mem_d[Rd] = DataInput;
    end

    // Reset wins over a write issued in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

`ifdef REGMEMORY_BYPASS_EN
    logic fwd_en;
    assign fwd_en = DataInputON && rst_n;

    always_comb begin
        Data1 = (fwd_en && (Ra == Rd)) ? DataInput : mem_q[Ra];
        Data2 = (fwd_en && (Rb == Rd)) ? DataInput : mem_q[Rb];
    end
`else
    always_comb begin
        Data1 = mem_q[Ra];
        Data2 = mem_q[Rb];
    end
`endif

endmodule

// File: tb/tb_reg_memory.sv
// Directed bench for reg_memory: vector table plus hand sequences for
// reset sweep, X write data while disabled, read-during-write and full fill.
module tb_reg_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  Ra, Rb, Rd;
    logic [31:0] DataInput;
    logic        DataInputON;
    logic [31:0] Data1, Data2;

    int total = 0;
    int bad   = 0;

    reg_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Ra          (Ra),
        .Rb          (Rb),
        .Rd          (Rd),
        .DataInput   (DataInput),
        .DataInputON (DataInputON),
        .Data1       (Data1),
        .Data2       (Data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        we;
        logic [3:0]  rd;
        logic [31:0] din;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic r, logic w, logic [3:0] d, logic [31:0] di,
                                logic [3:0] a, logic [3:0] b,
                                logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.rst_n = r; v.we = w; v.rd = d; v.din = di;
        v.ra = a; v.rb = b; v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, then idle the write port and read.
    task automatic step(input logic r, input logic w, input logic [3:0] d,
                        input logic [31:0] di, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst_n = r; DataInputON = w; Rd = d; DataInput = di; Ra = a; Rb = b;
        @(posedge clk);
        #1;
        rst_n = 1'b1; DataInputON = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; DataInputON = 1'b0; Rd = '0; DataInput = '0; Ra = '0; Rb = '0;

        vecs[0]  = mk(1'b0, 1'b0, 4'd0,  32'd0,          4'd0,  4'd15, 32'd0,          32'd0);
        vecs[1]  = mk(1'b1, 1'b1, 4'd0,  32'd100,        4'd0,  4'd1,  32'd100,        32'd0);
        vecs[2]  = mk(1'b1, 1'b1, 4'd2,  32'd100,        4'd2,  4'd0,  32'd100,        32'd100);
        vecs[3]  = mk(1'b1, 1'b0, 4'd1,  32'd77,         4'd1,  4'd3,  32'd0,          32'd0);
        vecs[4]  = mk(1'b1, 1'b0, 4'd5,  32'hDEADBEEF,   4'd5,  4'd2,  32'd0,          32'd100);
        vecs[5]  = mk(1'b1, 1'b0, 4'd5,  32'hDEADBEEF,   4'd5,  4'd2,  32'd0,          32'd100);
        vecs[6]  = mk(1'b1, 1'b1, 4'd7,  32'h12345678,   4'd7,  4'd7,  32'h12345678,   32'h12345678);
        vecs[7]  = mk(1'b1, 1'b1, 4'd7,  32'hCAFEF00D,   4'd7,  4'd7,  32'hCAFEF00D,   32'hCAFEF00D);
        vecs[8]  = mk(1'b0, 1'b1, 4'd3,  32'd55,         4'd3,  4'd0,  32'd0,          32'd0);
        vecs[9]  = mk(1'b1, 1'b0, 4'd0,  32'd0,          4'd2,  4'd7,  32'd0,          32'd0);
        vecs[10] = mk(1'b1, 1'b1, 4'd15, 32'hFFFFFFFF,   4'd15, 4'd14, 32'hFFFFFFFF,   32'd0);
        vecs[11] = mk(1'b1, 1'b1, 4'd8,  32'h80000001,   4'd8,  4'd15, 32'h80000001,   32'hFFFFFFFF);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].rd, vecs[i].din, vecs[i].ra, vecs[i].rb);
            check($sformatf("vec%0d.Data1", i), Data1, vecs[i].exp1);
            check($sformatf("vec%0d.Data2", i), Data2, vecs[i].exp2);
        end

        // X write data with enable low must leave every register untouched.
        @(negedge clk);
        DataInputON = 1'b0; Rd = 4'd15; DataInput = 'x; Ra = 4'd15; Rb = 4'd8;
        @(posedge clk);
        #1;
        check("xdata_off.R15", Data1, 32'hFFFFFFFF);
        check("xdata_off.R8",  Data2, 32'h80000001);

        // Read-during-write on the same index: old value before the edge unless forwarding.
        @(negedge clk);
        DataInputON = 1'b1; Rd = 4'd4; DataInput = 32'h0BADF00D; Ra = 4'd4; Rb = 4'd4;
        #1;
`ifdef REGMEMORY_BYPASS_EN
        check("rdw_pre.Data1", Data1, 32'h0BADF00D);
        check("rdw_pre.Data2", Data2, 32'h0BADF00D);
`else
        check("rdw_pre.Data1", Data1, 32'd0);
        check("rdw_pre.Data2", Data2, 32'd0);
`endif
        @(posedge clk);
        #1;
        DataInputON = 1'b0;
        #1;
        check("rdw_post.Data1", Data1, 32'h0BADF00D);
        check("rdw_post.Data2", Data2, 32'h0BADF00D);

        // Fill every register with a distinct pattern, then read through both ports.
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 4'(i), 32'hA5000000 | (i * 32'h00010101), 4'(i), 4'(i));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            Ra = 4'(i); Rb = 4'(15 - i);
            #1;
            check($sformatf("fill.R%0d", i), Data1, 32'hA5000000 | (i * 32'h00010101));
            check($sformatf("fill.R%0d", 15 - i), Data2, 32'hA5000000 | ((15 - i) * 32'h00010101));
        end

        // Reset sweep: every register returns to zero.
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            Ra = 4'(i); Rb = 4'(i);
            #1;
            check($sformatf("rst.R%0d.Data1", i), Data1, 32'd0);
            check($sformatf("rst.R%0d.Data2", i), Data2, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
